// File: rtl/mult_div_unit_pkg.sv
// rv32i_types: RV32M funct3 encoding and mult/div unit state encoding
package rv32i_types;

  typedef enum logic [2:0] {
    MO_MUL    = 3'd0,
    MO_MULH   = 3'd1,
    MO_MULHSU = 3'd2,
    MO_MULHU  = 3'd3,
    MO_DIV    = 3'd4,
    MO_DIVU   = 3'd5,
    MO_REM    = 3'd6,
    MO_REMU   = 3'd7
  } mul_ops_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  localparam int DIV_STEPS = 32;

  // Divide/remainder ops whose operands are two's complement (funct3 bit 0 clear)
  function automatic logic div_signed(input mul_ops_t op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// div_core: unsigned 32-bit restoring divider, one quotient bit per cycle
module div_core
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] r_rem, r_quo, r_dvs;
  logic [4:0]  r_cnt;
  logic        r_busy, r_done;
  logic [31:0] w_src_rem, w_src_quo, w_src_dvs;
  logic [32:0] w_sh, w_diff;
  logic        w_ge;

  // One restoring step; the start cycle performs the first step on the fresh operands
  always_comb begin
    w_src_rem = start ? 32'd0 : r_rem;
    w_src_quo = start ? dividend : r_quo;
    w_src_dvs = start ? divisor : r_dvs;
    w_sh      = {w_src_rem, w_src_quo[31]};
    w_diff    = w_sh - {1'b0, w_src_dvs};
    w_ge      = !w_diff[32];
  end

  // Iteration registers; done pulses the cycle after the 32nd step
  always_ff @(posedge clk) begin
    if (abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_busy && r_cnt == 5'd1 && !start;
      if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= 5'(DIV_STEPS - 1);
        r_dvs  <= divisor;
      end else if (r_busy) begin
        r_cnt  <= r_cnt - 5'd1;
        r_busy <= r_cnt != 5'd1;
      end
    end
    if (start || r_busy) begin
      r_rem <= w_ge ? w_diff[31:0] : w_sh[31:0];
      r_quo <= {w_src_quo[30:0], w_ge};
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign done      = r_done;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: RV32M execute unit with fixed-latency multiply and iterative divide
module mult_div_unit
  import rv32i_types::*;
#(
  parameter int MUL_LAT       = 2,
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [2:0]               issue_multop,
  input  logic [31:0]              issue_rs1_data,
  input  logic [31:0]              issue_rs2_data,
  input  logic [4:0]               issue_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] issue_rob_idx,
  input  logic                     flush,
  output logic                     unit_ready,
  output logic                     mul_valid,
  output logic [31:0]              mul_data,
  output logic [4:0]               mul_rd_addr,
  output logic [ROB_IDX_WIDTH-1:0] mul_rob_idx
);

  mdu_state_t r_state, w_next;
  mul_ops_t   r_op, w_op;
  logic [31:0] r_a, r_b, r_data;
  logic [4:0]  r_rd, r_out_rd;
  logic [ROB_IDX_WIDTH-1:0] r_rob, r_out_rob;
  logic [15:0] r_cnt;
  logic r_first, r_qneg, r_rneg, r_bz;
  logic w_idle, w_accept, w_load, w_sa, w_sb, w_neg_a, w_neg_b, w_start, w_abort, w_done;
  logic [31:0] w_ma, w_mb, w_abs_a, w_abs_b, w_quo, w_rem, w_q_fix, w_r_fix, w_result;
  logic signed [32:0] w_xa, w_xb;
  logic signed [63:0] w_prod;

  assign w_idle     = r_state == S_IDLE;
  assign unit_ready = w_idle && rst;
  assign w_accept   = issue_valid && unit_ready && !flush;

  // Multiply datapath; in IDLE it reads the issue port so a one-cycle latency still works
  always_comb begin
    w_op   = w_idle ? mul_ops_t'(issue_multop) : r_op;
    w_ma   = w_idle ? issue_rs1_data : r_a;
    w_mb   = w_idle ? issue_rs2_data : r_b;
    w_sa   = w_op != MO_MULHU;
    w_sb   = w_op == MO_MUL || w_op == MO_MULH;
    w_xa   = {w_sa & w_ma[31], w_ma};
    w_xb   = {w_sb & w_mb[31], w_mb};
    w_prod = 64'(w_xa) * 64'(w_xb);
  end

  // Divide sign handling: magnitudes into the core, signs reapplied on the way out
  always_comb begin
    w_neg_a  = div_signed(r_op) && r_a[31];
    w_neg_b  = div_signed(r_op) && r_b[31];
    w_abs_a  = w_neg_a ? -r_a : r_a;
    w_abs_b  = w_neg_b ? -r_b : r_b;
    w_q_fix  = r_bz ? 32'hFFFF_FFFF : r_qneg ? -w_quo : w_quo;
    w_r_fix  = r_bz ? r_a : r_rneg ? -w_rem : w_rem;
    w_result = r_state == S_DIV ? (r_op[1] ? w_r_fix : w_q_fix)
             : (w_op == MO_MUL ? w_prod[31:0] : w_prod[63:32]);
  end

  assign w_start = r_state == S_DIV && r_first;
  assign w_abort = flush || !rst;

  div_core u_div_core (
    .clk       (clk),
    .start     (w_start),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .abort     (w_abort),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_done)
  );

  // Next-state logic; flush always wins and drops whatever is in flight
  always_comb begin
    w_next = r_state;
    if (flush)
      w_next = S_IDLE;
    else if (r_state == S_IDLE)
      w_next = w_accept ? (issue_multop[2] ? S_DIV : (MUL_LAT == 1 ? S_DONE : S_MUL)) : S_IDLE;
    else if (r_state == S_MUL)
      w_next = r_cnt == 16'd1 ? S_DONE : S_MUL;
    else if (r_state == S_DIV)
      w_next = w_done ? S_DONE : S_DIV;
    else
      w_next = S_IDLE;
    w_load = w_next == S_DONE && r_state != S_DONE;
  end

  // State, operand latches and the held CDB output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= MO_MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_rob     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_bz      <= 1'b0;
      r_data    <= '0;
      r_out_rd  <= '0;
      r_out_rob <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= mul_ops_t'(issue_multop);
        r_a     <= issue_rs1_data;
        r_b     <= issue_rs2_data;
        r_rd    <= issue_rd_addr;
        r_rob   <= issue_rob_idx;
        r_cnt   <= 16'(MUL_LAT - 1);
        r_first <= 1'b1;
      end else begin
        r_first <= 1'b0;
        if (r_state == S_MUL)
          r_cnt <= r_cnt - 16'd1;
      end
      if (w_start) begin
        r_qneg <= w_neg_a ^ w_neg_b;
        r_rneg <= w_neg_a;
        r_bz   <= r_b == 32'd0;
      end
      if (w_load) begin
        r_data    <= w_result;
        r_out_rd  <= w_idle ? issue_rd_addr : r_rd;
        r_out_rob <= w_idle ? issue_rob_idx : r_rob;
      end
    end
  end

  assign mul_valid   = r_state == S_DONE && rst && !flush;
  assign mul_data    = r_data;
  assign mul_rd_addr = r_out_rd;
  assign mul_rob_idx = r_out_rob;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_multop = 3'd0;
  logic [31:0] issue_rs1_data = '0;
  logic [31:0] issue_rs2_data = '0;
  logic [4:0]  issue_rd_addr = '0;
  logic [4:0]  issue_rob_idx = '0;
  logic        flush = 1'b0;
  logic        unit_ready, mul_valid;
  logic [31:0] mul_data;
  logic [4:0]  mul_rd_addr, mul_rob_idx;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_acc = 0;

  mult_div_unit #(.MUL_LAT(2), .ROB_IDX_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_multop   (issue_multop),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data),
    .issue_rd_addr  (issue_rd_addr),
    .issue_rob_idx  (issue_rob_idx),
    .flush          (flush),
    .unit_ready     (unit_ready),
    .mul_valid      (mul_valid),
    .mul_data       (mul_data),
    .mul_rd_addr    (mul_rd_addr),
    .mul_rob_idx    (mul_rob_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an op at a negedge, hold until accepted, record the accept cycle
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [4:0] rob);
    int w;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_multop = op;
    issue_rs1_data = a;
    issue_rs2_data = b;
    issue_rd_addr = rd;
    issue_rob_idx = rob;
    w = 0;
    while (!unit_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!unit_ready) chk("accept_timeout", 32'(w), 32'd0);
    t_acc = cyc;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [4:0] rob,
                        input logic [31:0] exp, input int lat);
    int first;
    int pulses;
    start_op(op, a, b, rd, rob);
    first = -1;
    pulses = 0;
    for (int k = 1; k <= lat + 4; k++) begin
      @(negedge clk);
      if (mul_valid) begin
        pulses++;
        if (first < 0) begin
          first = cyc - t_acc;
          chk({tag, "_data"}, mul_data, exp);
          chk({tag, "_rd"}, 32'(mul_rd_addr), 32'(rd));
          chk({tag, "_rob"}, 32'(mul_rob_idx), 32'(rob));
        end
      end
    end
    chk({tag, "_lat"}, 32'(first), 32'(lat));
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int pulses;
    int acc;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(unit_ready), 32'd0);
    chk("rst_valid", 32'(mul_valid), 32'd0);
    chk("rst_data", mul_data, 32'd0);
    chk("rst_rd", 32'(mul_rd_addr), 32'd0);
    chk("rst_rob", 32'(mul_rob_idx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(unit_ready), 32'd1);

    run_op("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  5'd9,  32'hFFFF_FFEB, 2);
    run_op("mul_m1",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  5'd2,  32'h0000_0001, 2);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  5'd5,  32'hFFFF_FFFE, 2);
    run_op("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  5'd7,  32'h0000_0000, 2);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  5'd11, 32'hFFFF_FFFF, 2);
    run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 5'd12, 32'hFFFF_FFFD, 34);
    run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         5'd13, 5'd14, 32'hFFFF_FFFF, 34);
    run_op("divu",    3'd5, 32'd100,       32'd7,         5'd15, 5'd16, 32'd14,        34);
    run_op("remu",    3'd7, 32'd100,       32'd7,         5'd17, 5'd18, 32'd2,         34);
    run_op("divu_z",  3'd5, 32'd5,         32'd0,         5'd19, 5'd20, 32'hFFFF_FFFF, 34);
    run_op("remu_z",  3'd7, 32'd5,         32'd0,         5'd21, 5'd22, 32'd5,         34);
    run_op("div_z",   3'd4, 32'hFFFF_FFFB, 32'd0,         5'd23, 5'd24, 32'hFFFF_FFFF, 34);
    run_op("rem_z",   3'd6, 32'hFFFF_FFFB, 32'd0,         5'd25, 5'd26, 32'hFFFF_FFFB, 34);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 5'd28, 32'h8000_0000, 34);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd29, 5'd30, 32'h0000_0000, 34);

    start_op(3'd4, 32'd100, 32'd7, 5'd1, 5'd1);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mul_valid) pulses++;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        chk("flush_ready", 32'(unit_ready), 32'd1);
        flush = 1'b0;
      end
    end
    chk("flush_pulses", 32'(pulses), 32'd0);
    run_op("post_flush", 3'd0, 32'd6, 32'd7, 5'd2, 5'd3, 32'd42, 2);

    @(negedge clk);
    issue_valid = 1'b1;
    issue_multop = 3'd0;
    issue_rs1_data = 32'd3;
    issue_rs2_data = 32'd5;
    issue_rd_addr = 5'd4;
    issue_rob_idx = 5'd6;
    acc = 0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (unit_ready) acc++;
      if (mul_valid) begin
        pulses++;
        chk("held_data", mul_data, 32'd15);
      end
      @(negedge clk);
    end
    issue_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (mul_valid) pulses++;
      @(negedge clk);
    end
    chk("held_accepts", 32'(acc), 32'd4);
    chk("held_pulses", 32'(pulses), 32'd4);

    start_op(3'd5, 32'd100, 32'd7, 5'd9, 5'd9);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mul_valid) pulses++;
      if (k == 5) rst = 1'b0;
      if (k == 6) begin
        chk("rstmid_ready", 32'(unit_ready), 32'd0);
        chk("rstmid_data", mul_data, 32'd0);
        chk("rstmid_rd", 32'(mul_rd_addr), 32'd0);
        chk("rstmid_rob", 32'(mul_rob_idx), 32'd0);
        rst = 1'b1;
      end
      if (k == 7) chk("rstmid_ready_after", 32'(unit_ready), 32'd1);
    end
    chk("rstmid_pulses", 32'(pulses), 32'd0);
    run_op("post_rst", 3'd3, 32'h8000_0000, 32'd4, 5'd7, 5'd8, 32'd2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- RV32M execute unit. Consumes the mult/div reservation-station output (next_execute_mult_div) and drives the mul lane of the CDB (mul_valid, mul_data, mul_rd_addr, mul_rob_idx).
- Fixed-latency multiply and iterative 32-step restoring divide. One operation in flight.
- Its ready signal gates issue from the mult/div station. Flush aborts work silently.

Parameters:
- MUL_LAT, 2: cycles from accept to mul_valid for MUL* ops; must be >= 1.
- ROB_IDX_WIDTH, 5: width of ROB index fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- issue_valid  in  1  station entry valid with rs1/rs2 ready
- issue_multop  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- issue_rs1_data  in  32  operand A
- issue_rs2_data  in  32  operand B
- issue_rd_addr  in  5  destination arch reg
- issue_rob_idx  in  ROB_IDX_WIDTH  destination ROB index
- flush  in  1  pipeline flush (cdbus.flush)
- unit_ready  out  1  can accept this cycle
- mul_valid  out  1  one-cycle result pulse onto CDB
- mul_data  out  32  result
- mul_rd_addr  out  5  echoed rd_addr
- mul_rob_idx  out  ROB_IDX_WIDTH  echoed rob_idx

Behaviour:
- Reset (rst==0 at posedge): state IDLE, counters 0. unit_ready=0 during reset cycle, 1 after. mul_valid=0, mul_data=0, mul_rd_addr=0, mul_rob_idx=0. Reset mid-operation discards the operation; no pulse.
- States: IDLE, MUL, DIV, DONE.
- unit_ready = (state==IDLE) && rst.
- Accept on cycle t when issue_valid && unit_ready && !flush. Latch op, operands, rd_addr, rob_idx.
  - multop<4 -> MUL. Else -> DIV.
- MUL:
  - Operands sign- or zero-extended to 33 bits (MUL/MULH: s,s; MULHSU: s,u; MULHU: u,u). 66-bit product.
  - MUL returns bits[31:0]; the others return bits[63:32].
  - Counter runs so mul_valid rises at exactly t+MUL_LAT.
- DIV:
  - Cycle t+1: take absolute values for signed ops and record the quotient and remainder signs.
  - Then 32 restoring iterations, one bit per cycle, in div_core.
  - Then one sign-fix cycle. mul_valid at exactly t+34 for every divide, including special cases.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Divide special cases, final values:
  - B==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
  - DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM -> 0.
- DONE: mul_valid=1 and outputs driven for exactly one cycle, then IDLE. unit_ready is high the cycle after DONE, so back-to-back ops are spaced latency+1.
- mul_data/rd/rob outputs hold their last values when mul_valid=0; consumers must qualify with mul_valid.
- flush: any cycle with flush=1 forces IDLE next cycle, aborts the in-flight op and suppresses mul_valid, including in DONE. An issue in the same cycle as flush is not accepted.
- issue_valid while unit_ready=0 is ignored; the station holds the entry.
- No CDB back-pressure: the mul lane is dedicated.

Decomposition:
- rv32i_types holds the multop funct3 encoding enum (mul_ops_t) and the mdu state enum.
- Sub-module div_core: unsigned 32-bit restoring divider.
  - Inputs: start, dividend, divisor, abort.
  - Outputs: quotient, remainder, done.
  - 32 cycles from start to done.
- Sign handling and multiply stay in mult_div_unit.

Test Plan:
- MUL: A=7, B=0xFFFFFFFD (-3), accepted at t -> mul_valid only at t+2, mul_data=0xFFFFFFEB; rd/rob echoed.
- MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH: same operands -> 0x00000000. MULHSU: A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD at t+34; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Both at t+34.
- Flush at t+10 of a DIV -> no mul_valid through t+40; unit_ready=1 at t+11; a new MUL accepted then completes normally.
- issue_valid held continuously while busy -> exactly one result per accept, no duplicate pulses. rst low mid-DIV -> outputs zero, no pulse, unit_ready=1 the cycle after rst returns high.
